ts_meas_scheduler: RTL and testbench
====================================

TS_MEAS_SCHEDULER -- requirements
Module: ts_meas_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of sensor pulse-length data and result.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, idle cycles between consecutive sensor triggers in one burst.
REQ-003 SHALL have port clk_100MHz  input  1  control clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request for one averaged measurement.
REQ-006 SHALL have port auto_en  input  1  periodic measurement enable.
REQ-007 SHALL have port period  input  32  auto-mode trigger interval in cycles; 0 disables auto triggering.
REQ-008 SHALL have port navg_log2  input  3  samples per measurement = 2^navg_log2 (1..128).
REQ-009 SHALL have port timeout  input  32  per-sample wait limit in cycles; 0 disables timeout.
REQ-010 SHALL have port clr_err  input  1  clears sticky flags.
REQ-011 SHALL have port ts_valid  input  1  sensor completion strobe, one cycle.
REQ-012 SHALL have port ts_data  input  DATA_WIDTH  sensor pulse length, valid the cycle after ts_valid.
REQ-013 SHALL have port ts_pulse  output  1  one-cycle trigger to sensor pulse input.
REQ-014 SHALL have port result  output  DATA_WIDTH  averaged pulse length.
REQ-015 SHALL have port result_valid  output  1  one-cycle strobe when result updates.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port timeout_err  output  1  sticky: a sample timed out.
REQ-018 SHALL have port overrun  output  1  sticky: auto tick or start arrived while busy.

Function
REQ-019 SHALL implement states IDLE, TRIG, WAIT, CAPT, GAP, DONE; all outputs registered.
REQ-020 IDLE SHALL go to TRIG on start=1, or on auto tick; navg_log2 and timeout latched on this transition.
REQ-021 TRIG SHALL last exactly one cycle with ts_pulse=1, clear timeout counter, then go to WAIT.
REQ-022 WAIT SHALL increment the timeout counter each cycle; ts_valid=1 -> CAPT; counter reaching latched timeout (nonzero) -> set timeout_err, discard accumulator, go to IDLE without result_valid.
REQ-023 ts_valid and timeout expiry in the same cycle SHALL resolve as ts_valid (no error).
REQ-024 CAPT SHALL add ts_data into a DATA_WIDTH+7-bit accumulator and increment sample count; count==2^navg_log2 -> DONE, else -> GAP.
REQ-025 GAP SHALL wait GAP_CYCLES cycles then go to TRIG.
REQ-026 DONE SHALL load result = accumulator >> navg_log2 (truncated, lower DATA_WIDTH bits), pulse result_valid one cycle, clear accumulator and count, go to IDLE.
REQ-027 Auto period counter SHALL run whenever auto_en=1 and period!=0, producing a one-cycle tick every period cycles starting period cycles after enable; clearing auto_en or period=0 resets it to 0.
REQ-028 start or tick while busy SHALL be ignored and set overrun; start and tick together in IDLE SHALL launch one measurement.
REQ-029 clr_err=1 SHALL clear timeout_err and overrun next cycle; a set event in the same cycle SHALL win.
REQ-030 ts_valid outside WAIT SHALL be ignored.
REQ-031 Input changes to navg_log2/timeout while busy SHALL not affect the measurement in progress.

Reset
REQ-032 RESET SHALL force IDLE and clear ts_pulse, result, result_valid, busy, timeout_err, overrun, accumulator, sample count, timeout and period counters, asynchronously, including mid-measurement.
REQ-033 After RESET release, no ts_pulse SHALL occur without a start or auto tick.

Verification
REQ-034 navg_log2=0, start, sensor returns ts_valid after 200 cycles with ts_data=1234 -> one ts_pulse, result=1234, result_valid one cycle, busy low after.
REQ-035 navg_log2=2, samples 100,101,102,104 -> four ts_pulses spaced by sample time + GAP_CYCLES, result=101.
REQ-036 timeout=500, no ts_valid -> timeout_err set 500 cycles after TRIG, no result_valid, busy low; clr_err clears flag.
REQ-037 auto_en=1, period=10000, navg_log2=0 -> ts_pulse every 10000 cycles; start during measurement -> overrun=1, no extra pulse.
REQ-038 RESET asserted in WAIT with navg_log2=3 after 5 samples -> all outputs 0 immediately; next start yields result from fresh 8 samples only.
REQ-039 ts_valid coincident with timeout expiry -> sample accepted, timeout_err stays 0.

Source files
------------

// File: rtl/ts_meas_if.sv
// Handshake bundle between the measurement scheduler and its host/sensor side.
// The master drives requests and sensor returns; the slave (scheduler) drives triggers and results.
interface ts_meas_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  auto_en;
   logic [31:0]           period;
   logic [2:0]            navg_log2;
   logic [31:0]           timeout;
   logic                  clr_err;
   logic                  ts_valid;
   logic [DATA_WIDTH-1:0] ts_data;
   logic                  ts_pulse;
   logic [DATA_WIDTH-1:0] result;
   logic                  result_valid;
   logic                  busy;
   logic                  timeout_err;
   logic                  overrun;

   modport master (
      output start, auto_en, period, navg_log2, timeout, clr_err, ts_valid, ts_data,
      input  ts_pulse, result, result_valid, busy, timeout_err, overrun
   );

   modport slave (
      input  start, auto_en, period, navg_log2, timeout, clr_err, ts_valid, ts_data,
      output ts_pulse, result, result_valid, busy, timeout_err, overrun
   );
endinterface

// File: rtl/ts_meas_scheduler.sv
// Triggers a time-of-flight sensor 2^navg_log2 times per measurement, averages the
// returned pulse lengths, and reports timeouts and overruns as sticky flags.
module ts_meas_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int GAP_CYCLES = 16
) (
   input  logic      clk_100MHz,
   input  logic      RESET,
   ts_meas_if.slave  bus
);
   localparam int          ACC_W    = DATA_WIDTH + 7;
   localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TRIG = 3'd1,
      WAIT = 3'd2,
      CAPT = 3'd3,
      GAP  = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [7:0]            smp_q, smp_d;
   logic [31:0]           cyc_q, cyc_d;
   logic [31:0]           per_q, per_d;
   logic [2:0]            navg_q, navg_d;
   logic [31:0]           to_q, to_d;
   logic                  ts_pulse_q, ts_pulse_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  result_valid_q, result_valid_d;
   logic                  busy_q, busy_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  overrun_q, overrun_d;
   logic                  tick_s, launch_s, to_set_s, ovr_set_s;
   logic [7:0]            smp_inc_s;

   // Next-state, counter and flag computation for every register.
   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      smp_d          = smp_q;
      cyc_d          = cyc_q;
      per_d          = per_q;
      navg_d         = navg_q;
      to_d           = to_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      tick_s         = 1'b0;
      to_set_s       = 1'b0;
      smp_inc_s      = smp_q + 8'd1;

      // Free-running auto period counter; held at zero while disabled.
      if (bus.auto_en && (bus.period != 32'd0)) begin
         if (per_q == (bus.period - 32'd1)) begin
            per_d  = 32'd0;
            tick_s = 1'b1;
         end else begin
            per_d  = per_q + 32'd1;
            tick_s = 1'b0;
         end
      end else begin
         per_d  = 32'd0;
         tick_s = 1'b0;
      end

      launch_s  = bus.start || tick_s;
      ovr_set_s = launch_s && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (launch_s) begin
               state_d = TRIG;
               navg_d  = bus.navg_log2;
               to_d    = bus.timeout;
            end else begin
               state_d = IDLE;
            end
         end
         TRIG: begin
            cyc_d   = 32'd0;
            state_d = WAIT;
         end
         WAIT: begin
            // A strobe on the expiry cycle still counts as a good sample.
            if (bus.ts_valid) begin
               state_d = CAPT;
            end else if ((to_q != 32'd0) && ((cyc_q + 32'd1) == to_q)) begin
               to_set_s = 1'b1;
               acc_d    = '0;
               smp_d    = 8'd0;
               state_d  = IDLE;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         CAPT: begin
            acc_d = acc_q + ACC_W'(bus.ts_data);
            smp_d = smp_inc_s;
            cyc_d = 32'd0;
            if (smp_inc_s == (8'd1 << navg_q)) begin
               state_d = DONE;
            end else begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (cyc_q == GAP_LAST) begin
               state_d = TRIG;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         DONE: begin
            result_d       = DATA_WIDTH'(acc_q >> navg_q);
            result_valid_d = 1'b1;
            acc_d          = '0;
            smp_d          = 8'd0;
            state_d        = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ts_pulse_d = (state_d == TRIG);
      busy_d     = (state_d != IDLE);

      // Sticky flags: a new event outranks a simultaneous clear.
      if (to_set_s) begin
         timeout_err_d = 1'b1;
      end else if (bus.clr_err) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end

      if (ovr_set_s) begin
         overrun_d = 1'b1;
      end else if (bus.clr_err) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_100MHz or posedge RESET) begin
      if (RESET) begin
         state_q        <= IDLE;
         acc_q          <= '0;
         smp_q          <= 8'd0;
         cyc_q          <= 32'd0;
         per_q          <= 32'd0;
         navg_q         <= 3'd0;
         to_q           <= 32'd0;
         ts_pulse_q     <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         smp_q          <= smp_d;
         cyc_q          <= cyc_d;
         per_q          <= per_d;
         navg_q         <= navg_d;
         to_q           <= to_d;
         ts_pulse_q     <= ts_pulse_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         busy_q         <= busy_d;
         timeout_err_q  <= timeout_err_d;
         overrun_q      <= overrun_d;
      end
   end

   assign bus.ts_pulse     = ts_pulse_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.busy         = busy_q;
   assign bus.timeout_err  = timeout_err_q;
   assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_ts_meas_scheduler.sv
// Scenario bench for ts_meas_scheduler: a behavioural sensor answers each trigger,
// and a result scoreboard checks every averaged measurement the DUT reports.
module tb_ts_meas_scheduler;
   localparam int DW  = 32;
   localparam int GAP = 16;

   typedef struct {
      int          delay;
      logic [31:0] data;
   } samp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   rv_cnt;

   samp_t       sens_q[$];
   samp_t       sens_cur;
   logic [31:0] exp_q[$];
   int          pulse_t[$];

   ts_meas_if #(.DATA_WIDTH(DW)) bus ();

   ts_meas_scheduler #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
      .clk_100MHz (clk),
      .RESET      (rst),
      .bus        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time-stamp triggers.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record triggers and score each reported result.
   always @(negedge clk) begin
      if (bus.ts_pulse === 1'b1) pulse_t.push_back(cyc);
      if (bus.result_valid === 1'b1) begin
         rv_cnt   = rv_cnt + 1;
         n_checks = n_checks + 1;
         if (exp_q.size() == 0) begin
            $display("FAIL result_unexpected: got %0d, required no result", bus.result);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.result !== e) $display("FAIL result: got %0d, required %0d", bus.result, e);
            else n_pass = n_pass + 1;
         end
      end
   end

   // Sensor model: answers a trigger after the queued delay, data one cycle after the strobe.
   initial begin
      bus.ts_valid = 1'b0;
      bus.ts_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.ts_pulse === 1'b1 && sens_q.size() > 0) begin
            sens_cur = sens_q.pop_front();
            repeat (sens_cur.delay) @(posedge clk);
            #1 bus.ts_valid = 1'b1;
            @(posedge clk);
            #1 bus.ts_valid = 1'b0;
            bus.ts_data = sens_cur.data;
            @(posedge clk);
            #1 bus.ts_data = '0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
   endtask

   task automatic push_sample(input int d, input logic [31:0] v);
      samp_t s;
      s.delay = d;
      s.data  = v;
      sens_q.push_back(s);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while ((bus.busy !== 1'b0 || exp_q.size() != 0) && k < budget) begin
         step(1);
         k++;
      end
      n_checks++;
      if (k >= budget) $display("FAIL %s_wait: busy=%b pending=%0d, required idle within %0d cycles", name, bus.busy, exp_q.size(), budget);
      else n_pass++;
   endtask

   task automatic wait_pulses(input string name, input int n, input int budget);
      int k;
      k = 0;
      while (pulse_t.size() < n && k < budget) begin
         step(1);
         k++;
      end
      n_checks++;
      if (k >= budget) $display("FAIL %s_pulses: got %0d, required %0d within %0d cycles", name, pulse_t.size(), n, budget);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      n_checks++; if (bus.ts_pulse !== 1'b0) $display("FAIL rst_pulse: got %b, required 0", bus.ts_pulse); else n_pass++;
      n_checks++; if (bus.result !== 32'd0) $display("FAIL rst_result: got %0d, required 0", bus.result); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy); else n_pass++;
      n_checks++; if ({bus.timeout_err, bus.overrun} !== 2'b00) $display("FAIL rst_flags: got %b, required 00", {bus.timeout_err, bus.overrun}); else n_pass++;
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_single();
      int rv0;
      bus.navg_log2 = 3'd0;
      bus.timeout   = 32'd0;
      push_sample(200, 32'd1234);
      exp_q.push_back(32'd1234);
      pulse_t.delete();
      rv0 = rv_cnt;
      pulse_start();
      wait_idle("single", 1000);
      step(3);
      n_checks++; if (pulse_t.size() != 1) $display("FAIL single_pulses: got %0d, required 1", pulse_t.size()); else n_pass++;
      n_checks++; if (rv_cnt - rv0 != 1) $display("FAIL single_rv: got %0d strobes, required 1", rv_cnt - rv0); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy: got %b, required 0", bus.busy); else n_pass++;
   endtask

   task automatic test_average();
      int          dly[4];
      logic [31:0] val[4];
      logic [38:0] sum;
      dly = '{20, 35, 50, 65};
      val = '{32'd100, 32'd101, 32'd102, 32'd104};
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         push_sample(dly[i], val[i]);
         sum = sum + 39'(val[i]);
      end
      exp_q.push_back(32'(sum >> 2));
      bus.navg_log2 = 3'd2;
      pulse_t.delete();
      pulse_start();
      bus.navg_log2 = 3'd7;
      wait_idle("avg", 2000);
      n_checks++; if (pulse_t.size() != 4) $display("FAIL avg_pulses: got %0d, required 4", pulse_t.size()); else n_pass++;
      // Trigger spacing: response delay + strobe/capture cycles + gap.
      for (int i = 0; i < 3; i++) begin
         if (pulse_t.size() > i + 1) begin
            n_checks++;
            if (pulse_t[i+1] - pulse_t[i] != dly[i] + 2 + GAP)
               $display("FAIL avg_spacing%0d: got %0d, required %0d", i, pulse_t[i+1] - pulse_t[i], dly[i] + 2 + GAP);
            else n_pass++;
         end
      end
      bus.navg_log2 = 3'd0;
   endtask

   task automatic test_timeout();
      int k;
      int t_err;
      int rv0;
      bus.navg_log2 = 3'd0;
      bus.timeout   = 32'd500;
      pulse_t.delete();
      rv0 = rv_cnt;
      pulse_start();
      k = 0;
      while (bus.timeout_err !== 1'b1 && k < 1000) begin
         step(1);
         k++;
      end
      t_err = cyc;
      n_checks++;
      // Flag appears after the TRIG cycle plus 500 full WAIT cycles.
      if (pulse_t.size() != 1 || t_err - pulse_t[0] != 501)
         $display("FAIL timeout_delay: got %0d cycles (%0d pulses), required 501", (pulse_t.size() > 0) ? t_err - pulse_t[0] : -1, pulse_t.size());
      else n_pass++;
      step(2);
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL timeout_busy: got %b, required 0", bus.busy); else n_pass++;
      n_checks++; if (rv_cnt != rv0) $display("FAIL timeout_rv: got %0d strobes, required 0", rv_cnt - rv0); else n_pass++;
      bus.clr_err = 1'b1;
      step(1);
      bus.clr_err = 1'b0;
      n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL timeout_clr: got %b, required 0", bus.timeout_err); else n_pass++;
   endtask

   task automatic test_coincident();
      bus.timeout = 32'd300;
      push_sample(300, 32'd777);
      exp_q.push_back(32'd777);
      pulse_start();
      wait_idle("coinc", 1000);
      n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL coinc_err: got %b, required 0", bus.timeout_err); else n_pass++;
      bus.timeout = 32'd0;
   endtask

   task automatic test_auto();
      int e;
      for (int i = 0; i < 3; i++) begin
         push_sample(200, 32'(1000 + i));
         exp_q.push_back(32'(1000 + i));
      end
      pulse_t.delete();
      bus.period  = 32'd10000;
      bus.auto_en = 1'b1;
      e = cyc;
      wait_pulses("auto2", 2, 25000);
      step(5);
      pulse_start();
      n_checks++; if (bus.overrun !== 1'b1) $display("FAIL auto_overrun: got %b, required 1", bus.overrun); else n_pass++;
      wait_pulses("auto3", 3, 15000);
      wait_idle("auto", 1000);
      bus.auto_en = 1'b0;
      step(20);
      n_checks++; if (pulse_t.size() != 3) $display("FAIL auto_count: got %0d, required 3", pulse_t.size()); else n_pass++;
      if (pulse_t.size() >= 3) begin
         n_checks++; if (pulse_t[0] - e != 10000) $display("FAIL auto_first: got %0d, required 10000", pulse_t[0] - e); else n_pass++;
         n_checks++; if (pulse_t[1] - pulse_t[0] != 10000) $display("FAIL auto_period1: got %0d, required 10000", pulse_t[1] - pulse_t[0]); else n_pass++;
         n_checks++; if (pulse_t[2] - pulse_t[1] != 10000) $display("FAIL auto_period2: got %0d, required 10000", pulse_t[2] - pulse_t[1]); else n_pass++;
      end
      bus.clr_err = 1'b1;
      step(1);
      bus.clr_err = 1'b0;
      n_checks++; if (bus.overrun !== 1'b0) $display("FAIL auto_clr: got %b, required 0", bus.overrun); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [38:0] sum;
      bus.navg_log2 = 3'd3;
      for (int i = 0; i < 5; i++) push_sample(10, 32'(50 + 7 * i));
      pulse_t.delete();
      pulse_start();
      wait_pulses("rmid", 6, 2000);
      step(3);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (bus.ts_pulse !== 1'b0) $display("FAIL rmid_pulse: got %b, required 0", bus.ts_pulse); else n_pass++;
      n_checks++; if (bus.result !== 32'd0) $display("FAIL rmid_result: got %0d, required 0", bus.result); else n_pass++;
      n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL rmid_rv: got %b, required 0", bus.result_valid); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy: got %b, required 0", bus.busy); else n_pass++;
      step(2);
      rst = 1'b0;
      pulse_t.delete();
      step(20);
      n_checks++; if (pulse_t.size() != 0) $display("FAIL rmid_spurious: got %0d pulses, required 0", pulse_t.size()); else n_pass++;
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         push_sample(12, 32'(1000 + 3 * i));
         sum = sum + 39'(1000 + 3 * i);
      end
      exp_q.push_back(32'(sum >> 3));
      pulse_start();
      wait_idle("rmid", 3000);
      n_checks++; if (pulse_t.size() != 8) $display("FAIL rmid_fresh: got %0d pulses, required 8", pulse_t.size()); else n_pass++;
   endtask

   initial begin
      cyc           = 0;
      n_checks      = 0;
      n_pass        = 0;
      rv_cnt        = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.auto_en   = 1'b0;
      bus.period    = 32'd0;
      bus.navg_log2 = 3'd0;
      bus.timeout   = 32'd0;
      bus.clr_err   = 1'b0;
      test_reset();
      test_single();
      test_average();
      test_timeout();
      test_coincident();
      test_auto();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
